// File: rtl/s_mem_arbiter_pkg.sv
// s_mem_pkg
// Shared definitions for the s_memory arbiter: default RAM geometry,
// requester indices for the RC4 phase FSMs and the arbiter state type.
// No ports (package).

package s_mem_pkg;

  localparam int ADDR_W_DEF = 8;
  localparam int DATA_W_DEF = 8;

  localparam int REQ_INIT = 0;
  localparam int REQ_KSA  = 1;
  localparam int REQ_PRGA = 2;

  typedef enum logic {
    ARB_IDLE,
    ARB_LOCKED
  } arb_state_e;

endpackage

// File: rtl/s_mem_arbiter_grant_sel.sv
// s_mem_grant_sel
// Combinational one-hot selector. Scans the request vector starting at
// ptr_i and wrapping around, returning the first asserted request as a
// one-hot grant. Fixed priority is the same search with ptr_i tied to 0.
//
// Ports:
//   req_i  in  NUM_REQ  request vector
//   ptr_i  in  PTR_W    index the search starts from
//   gnt_o  out NUM_REQ  one-hot winner, all zero when no request

module s_mem_grant_sel
  import s_mem_pkg::*;
#(
  parameter int NUM_REQ = 3,
  parameter int PTR_W   = 2
) (
  input  logic [NUM_REQ-1:0] req_i,
  input  logic [PTR_W-1:0]   ptr_i,
  output logic [NUM_REQ-1:0] gnt_o
);

  logic [PTR_W-1:0] idx;
  logic             found;

  // First asserted request in rotated order wins; found blocks later hits.
  always_comb begin
    gnt_o = '0;
    found = 1'b0;
    idx   = '0;
    for (int k = 0; k < NUM_REQ; k++) begin
      idx = PTR_W'((int'(ptr_i) + k) % NUM_REQ);
      if (!found && req_i[idx]) begin
        gnt_o[idx] = 1'b1;
        found      = 1'b1;
      end
    end
  end

endmodule

// File: rtl/s_mem_arbiter.sv
// s_mem_arbiter
// Shares the single-port s_memory RAM between the RC4 phase FSMs
// (init, KSA, PRGA). Each requester has a request/grant port with a
// one-cycle read return, and can lock the RAM across several transfers
// for atomic read-modify-write sequences such as the KSA swap.
//
// Build option: define S_MEM_ARB_RR_EN for round-robin selection;
// otherwise fixed priority with the lowest index winning.
//
// Ports:
//   clk          in   system clock
//   reset        in   asynchronous active-high reset
//   req/we/lock  in   per-requester request, write enable, lock hold
//   addr/wdata   in   packed per-requester address and write data
//   gnt          out  one-hot grant (transfer when req[i] & gnt[i])
//   rvalid       out  one-hot read-return strobe, one cycle after a read
//   rdata        out  shared read data, valid with rvalid
//   mem_address, mem_data, mem_wren  out  to s_memory
//   mem_q        in   from s_memory

module s_mem_arbiter
  import s_mem_pkg::*;
#(
  parameter int ADDR_W  = ADDR_W_DEF,
  parameter int DATA_W  = DATA_W_DEF,
  parameter int NUM_REQ = 3
) (
  input  logic                      clk,
  input  logic                      reset,
  input  logic [NUM_REQ-1:0]        req,
  input  logic [NUM_REQ-1:0]        we,
  input  logic [NUM_REQ-1:0]        lock,
  input  logic [NUM_REQ*ADDR_W-1:0] addr,
  input  logic [NUM_REQ*DATA_W-1:0] wdata,
  output logic [NUM_REQ-1:0]        gnt,
  output logic [NUM_REQ-1:0]        rvalid,
  output logic [DATA_W-1:0]         rdata,
  output logic [ADDR_W-1:0]         mem_address,
  output logic [DATA_W-1:0]         mem_data,
  output logic                      mem_wren,
  input  logic [DATA_W-1:0]         mem_q
);

  localparam int PTR_W = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;

  arb_state_e         state_q, state_d;
  logic [PTR_W-1:0]   owner_q, owner_d;
  logic               rdPend_q, rdPend_d;
  logic [PTR_W-1:0]   rdId_q, rdId_d;

  logic [PTR_W-1:0]   selPtr;
  logic [NUM_REQ-1:0] selGnt;
  logic [NUM_REQ-1:0] ownerMask;
  logic [PTR_W-1:0]   win;
  logic               xfer;

  logic [ADDR_W-1:0]  addrArr  [NUM_REQ];
  logic [DATA_W-1:0]  wdataArr [NUM_REQ];

  for (genvar g = 0; g < NUM_REQ; g++) begin : g_unpack
    assign addrArr[g]  = addr[g*ADDR_W +: ADDR_W];
    assign wdataArr[g] = wdata[g*DATA_W +: DATA_W];
  end

`ifdef S_MEM_ARB_RR_EN
  logic [PTR_W-1:0] rrPtr_q, rrPtr_d;
  assign selPtr = rrPtr_q;
`else
  assign selPtr = '0;
`endif

  s_mem_grant_sel #(
    .NUM_REQ (NUM_REQ),
    .PTR_W   (PTR_W)
  ) u_grant_sel (
    .req_i (req),
    .ptr_i (selPtr),
    .gnt_o (selGnt)
  );

  // While locked only the owner can be granted, and only when it requests.
  // Grant is forced low during reset so nothing reaches the RAM.
  always_comb begin
    ownerMask          = '0;
    ownerMask[owner_q] = 1'b1;
    gnt                = '0;
    if (!reset) begin
      if (state_q == ARB_LOCKED) begin
        gnt = req & ownerMask;
      end else begin
        gnt = selGnt;
      end
    end
  end

  always_comb begin
    win = '0;
    for (int i = 0; i < NUM_REQ; i++) begin
      if (gnt[i]) begin
        win = PTR_W'(i);
      end
    end
  end

  assign xfer = |gnt;

  // Memory mux, read tracking and lock FSM next state.
  always_comb begin
    state_d     = state_q;
    owner_d     = owner_q;
    rdPend_d    = 1'b0;
    rdId_d      = rdId_q;
    mem_address = '0;
    mem_data    = '0;
    mem_wren    = 1'b0;

    if (xfer) begin
      mem_address = addrArr[win];
      mem_data    = wdataArr[win];
      mem_wren    = we[win];
      rdPend_d    = ~we[win];
      rdId_d      = win;
    end

    case (state_q)
      ARB_IDLE: begin
        if (xfer && lock[win]) begin
          state_d = ARB_LOCKED;
          owner_d = win;
        end
      end
      ARB_LOCKED: begin
        // Released by the owner's last transfer or by an idle owner dropping
        // lock; both reduce to lock[owner] going low.
        if (!lock[owner_q]) begin
          state_d = ARB_IDLE;
        end
      end
      default: state_d = ARB_IDLE;
    endcase
  end

`ifdef S_MEM_ARB_RR_EN
  // Pointer moves past the winner only for transfers granted from IDLE.
  always_comb begin
    rrPtr_d = rrPtr_q;
    if (state_q == ARB_IDLE && xfer) begin
      rrPtr_d = (int'(win) == NUM_REQ - 1) ? '0 : win + 1'b1;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      rrPtr_q <= '0;
    end else begin
      rrPtr_q <= rrPtr_d;
    end
  end
`endif

  // Read return: strobe the requester that read last cycle with RAM output.
  always_comb begin
    rvalid = '0;
    rdata  = '0;
    if (rdPend_q) begin
      rvalid[rdId_q] = 1'b1;
      rdata          = mem_q;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q  <= ARB_IDLE;
      owner_q  <= '0;
      rdPend_q <= 1'b0;
      rdId_q   <= '0;
    end else begin
      state_q  <= state_d;
      owner_q  <= owner_d;
      rdPend_q <= rdPend_d;
      rdId_q   <= rdId_d;
    end
  end

endmodule
